shot_resolver_fsm: RTL and testbench

//   Battleships game-state stage that resolves player shots against the ship map.

---
 rtl/battleship_pkg.sv | 32 +++
 rtl/shot_history_ram.sv | 46 ++++
 rtl/shot_resolver_fsm.sv | 165 ++++++++++++++++
 tb/tb_shot_resolver_fsm.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/battleship_pkg.sv
// Shared constants, result codes and state encodings for the battleships shot resolver.
package battleship_pkg;

    localparam int unsigned GRID_DEFAULT       = 10;
    localparam int unsigned MAX_TURNS_DEFAULT  = 20;
    localparam int unsigned SHIP_CELLS_DEFAULT = 17;

    localparam int unsigned COORD_W = 4;
    localparam int unsigned IDX_W   = 8;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned RES_W   = 2;
    localparam int unsigned ST_W    = 3;

    localparam logic [RES_W-1:0] RES_NONE   = 2'd0;
    localparam logic [RES_W-1:0] RES_MISS   = 2'd1;
    localparam logic [RES_W-1:0] RES_HIT    = 2'd2;
    localparam logic [RES_W-1:0] RES_REJECT = 2'd3;

    localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [ST_W-1:0] ST_CHECK   = 3'd1;
    localparam logic [ST_W-1:0] ST_RESOLVE = 3'd2;
    localparam logic [ST_W-1:0] ST_WIN     = 3'd3;
    localparam logic [ST_W-1:0] ST_LOSE    = 3'd4;

    // Linear cell index; rows up to 15 on a 16-wide board still fit IDX_W.
    function automatic logic [IDX_W-1:0] cell_index(input logic [COORD_W-1:0] row,
                                                    input logic [COORD_W-1:0] col,
                                                    input int unsigned        grid);
        return IDX_W'(32'(row) * grid + 32'(col));
    endfunction

endpackage

// File: rtl/shot_history_ram.sv
// Per-cell "already fired" flags: synchronous set of one cell, clear-all, single-bit lookup.
module shot_history_ram
    import battleship_pkg::*;
#(
    parameter int unsigned CELLS = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             set,
    input  logic [IDX_W-1:0] set_idx,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_bit_c,
    output logic [CELLS-1:0] flags
);

    logic [CELLS-1:0] flags_q;
    logic [CELLS-1:0] flags_d;

    always_comb begin
        flags_d = flags_q;
        if (clr) begin
            flags_d = '0;
        end else if (set) begin
            for (int i = 0; i < int'(CELLS); i++) begin
                if (set_idx == IDX_W'(i)) flags_d[i] = 1'b1;
            end
        end
    end

    // Out-of-range indices read as 0; the caller rejects them anyway.
    always_comb begin
        rd_bit_c = 1'b0;
        for (int i = 0; i < int'(CELLS); i++) begin
            if (rd_idx == IDX_W'(i)) rd_bit_c = flags_q[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) flags_q <= '0;
        else       flags_q <= flags_d;
    end

    assign flags = flags_q;

endmodule

// File: rtl/shot_resolver_fsm.sv
// Battleships shot resolver: IDLE -> CHECK -> RESOLVE -> {IDLE|WIN|LOSE}, with turn/hit counters.
module shot_resolver_fsm
    import battleship_pkg::*;
#(
    parameter int unsigned GRID       = GRID_DEFAULT,
    parameter int unsigned MAX_TURNS  = MAX_TURNS_DEFAULT,
    parameter int unsigned SHIP_CELLS = SHIP_CELLS_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   new_game,
    input  logic                   fire,
    input  logic [COORD_W-1:0]     target_row,
    input  logic [COORD_W-1:0]     target_col,
    input  logic [GRID*GRID-1:0]   ship_map,
    output logic [CNT_W-1:0]       turns_left,
    output logic [CNT_W-1:0]       hits,
    output logic                   win,
    output logic                   lose,
    output logic [GRID*GRID-1:0]   shot_map,
    output logic [RES_W-1:0]       result,
    output logic                   busy
);

    localparam int unsigned CELLS = GRID * GRID;

    logic [ST_W-1:0]    state_q, state_d;
    logic [COORD_W-1:0] row_q, row_d, col_q, col_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d, rpt_q, rpt_d, hit_q, hit_d;
    logic [CNT_W-1:0]   turns_q, turns_d, hits_q, hits_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               win_q, win_d, lose_q, lose_d, busy_q, busy_d;

    logic [IDX_W-1:0]   idx_c;
    logic               shot_rd_c, ship_rd_c, map_set_c, map_clr_c;

    assign idx_c = cell_index(row_q, col_q, GRID);

    shot_history_ram #(.CELLS(CELLS)) u_history (
        .clk      (clk),
        .reset    (reset),
        .clr      (map_clr_c),
        .set      (map_set_c),
        .set_idx  (idx_q),
        .rd_idx   (idx_c),
        .rd_bit_c (shot_rd_c),
        .flags    (shot_map)
    );

    always_comb begin
        ship_rd_c = 1'b0;
        for (int i = 0; i < int'(CELLS); i++) begin
            if (idx_c == IDX_W'(i)) ship_rd_c = ship_map[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        rpt_d     = rpt_q;
        hit_d     = hit_q;
        turns_d   = turns_q;
        hits_d    = hits_q;
        result_d  = result_q;
        map_set_c = 1'b0;
        map_clr_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fire) begin
                    row_d   = target_row;
                    col_d   = target_col;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                idx_d   = idx_c;
                valid_d = (32'(row_q) < GRID) && (32'(col_q) < GRID);
                rpt_d   = shot_rd_c;
                hit_d   = ship_rd_c;
                state_d = ST_RESOLVE;
            end
            ST_RESOLVE: begin
                if (!valid_q || rpt_q) begin
                    result_d = RES_REJECT;
                end else begin
                    map_set_c = 1'b1;
                    if (turns_q != '0) turns_d = turns_q - CNT_W'(1);
                    if (hit_q) begin
                        if (32'(hits_q) < SHIP_CELLS) hits_d = hits_q + CNT_W'(1);
                        result_d = RES_HIT;
                    end else begin
                        result_d = RES_MISS;
                    end
                end
                // Winning on the final turn takes priority over running out of turns.
                if (hits_d == CNT_W'(SHIP_CELLS))  state_d = ST_WIN;
                else if (turns_d == '0)            state_d = ST_LOSE;
                else                               state_d = ST_IDLE;
            end
            ST_WIN, ST_LOSE: state_d = state_q;
            default:         state_d = ST_IDLE;
        endcase

        if (new_game) begin
            state_d   = ST_IDLE;
            turns_d   = CNT_W'(MAX_TURNS);
            hits_d    = '0;
            result_d  = RES_NONE;
            valid_d   = 1'b0;
            rpt_d     = 1'b0;
            hit_d     = 1'b0;
            map_set_c = 1'b0;
            map_clr_c = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
        win_d  = (state_d == ST_WIN);
        lose_d = (state_d == ST_LOSE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            rpt_q    <= 1'b0;
            hit_q    <= 1'b0;
            turns_q  <= CNT_W'(MAX_TURNS);
            hits_q   <= '0;
            result_q <= RES_NONE;
            win_q    <= 1'b0;
            lose_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            rpt_q    <= rpt_d;
            hit_q    <= hit_d;
            turns_q  <= turns_d;
            hits_q   <= hits_d;
            result_q <= result_d;
            win_q    <= win_d;
            lose_q   <= lose_d;
            busy_q   <= busy_d;
        end
    end

    assign turns_left = turns_q;
    assign hits       = hits_q;
    assign win        = win_q;
    assign lose       = lose_q;
    assign result     = result_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_shot_resolver_fsm.sv
// Scoreboard bench for shot_resolver_fsm: stimulus queues expected outcomes, a monitor checks them.
module tb_shot_resolver_fsm;
    import battleship_pkg::*;

    localparam int unsigned GRID  = 10;
    localparam int unsigned CELLS = GRID * GRID;

    logic             clk = 1'b0;
    logic             reset, new_game, fire;
    logic [3:0]       target_row, target_col;
    logic [CELLS-1:0] ship_map;
    logic [4:0]       turns_left, hits;
    logic             win, lose, busy;
    logic [CELLS-1:0] shot_map;
    logic [1:0]       result;

    shot_resolver_fsm #(.GRID(10), .MAX_TURNS(20), .SHIP_CELLS(17)) dut (
        .clk        (clk),
        .reset      (reset),
        .new_game   (new_game),
        .fire       (fire),
        .target_row (target_row),
        .target_col (target_col),
        .ship_map   (ship_map),
        .turns_left (turns_left),
        .hits       (hits),
        .win        (win),
        .lose       (lose),
        .shot_map   (shot_map),
        .result     (result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]       res;
        logic [4:0]       turns;
        logic [4:0]       hits;
        logic             win;
        logic             lose;
        logic [CELLS-1:0] smap;
    } exp_t;

    exp_t             sb_q[$];
    int               checks = 0;
    int               errors = 0;
    logic [CELLS-1:0] exp_map;
    int               ship_idx[17] = '{0, 1, 2, 3, 4, 10, 11, 12, 13, 50, 51, 52, 75, 76, 77, 98, 99};

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: each accepted shot raises busy; its outcome is visible two edges later.
    initial begin
        logic busy_prev;
        exp_t e;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1 && busy_prev !== 1'b1) begin
                repeat (2) @(negedge clk);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_shot actual=shot expected=none at %0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    check("result", 128'(result), 128'(e.res));
                    check("turns_left", 128'(turns_left), 128'(e.turns));
                    check("hits", 128'(hits), 128'(e.hits));
                    check("win", 128'(win), 128'(e.win));
                    check("lose", 128'(lose), 128'(e.lose));
                    check("shot_map", 128'(shot_map), 128'(e.smap));
                end
            end
            busy_prev = busy;
        end
    end

    task automatic shoot(input int r, input int c, input logic [1:0] res,
                         input int t, input int h, input logic w, input logic l);
        exp_t e;
        if (res == RES_MISS || res == RES_HIT) exp_map[r * int'(GRID) + c] = 1'b1;
        e.res = res; e.turns = 5'(t); e.hits = 5'(h); e.win = w; e.lose = l; e.smap = exp_map;
        sb_q.push_back(e);
        @(negedge clk);
        for (int i = 0; i < 20 && busy !== 1'b0; i++) @(negedge clk);
        if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual=busy expected=idle at %0t", $time);
        end
        target_row = 4'(r);
        target_col = 4'(c);
        fire = 1'b1;
        @(negedge clk);
        fire = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_turns"}, 128'(turns_left), 128'(20));
        check({tag, "_hits"}, 128'(hits), 128'(0));
        check({tag, "_win"}, 128'(win), 128'(0));
        check({tag, "_lose"}, 128'(lose), 128'(0));
        check({tag, "_shot_map"}, 128'(shot_map), 128'(0));
        check({tag, "_result"}, 128'(result), 128'(RES_NONE));
        check({tag, "_busy"}, 128'(busy), 128'(0));
    endtask

    task automatic pulse_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        exp_map = '0;
    endtask

    task automatic ignored_fire(input int r, input int c);
        @(negedge clk);
        target_row = 4'(r);
        target_col = 4'(c);
        fire = 1'b1;
        @(negedge clk);
        fire = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; new_game = 1'b0; fire = 1'b0;
        target_row = '0; target_col = '0; exp_map = '0;
        ship_map = '0;
        foreach (ship_idx[k]) ship_map[ship_idx[k]] = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("rst");

        // Miss at (2,3)
        shoot(2, 3, RES_MISS, 19, 0, 1'b0, 1'b0);
        check("cell23_set", 128'(shot_map[23]), 128'(1));

        // Hit then repeat the same cell
        pulse_new_game();
        check_reset_values("ng1");
        shoot(0, 0, RES_HIT, 19, 1, 1'b0, 1'b0);
        shoot(0, 0, RES_REJECT, 19, 1, 1'b0, 1'b0);

        // Out-of-range coordinates
        pulse_new_game();
        shoot(12, 0, RES_REJECT, 20, 0, 1'b0, 1'b0);
        shoot(0, 10, RES_REJECT, 20, 0, 1'b0, 1'b0);

        // new_game and fire together: the shot must not start
        @(negedge clk);
        new_game = 1'b1; fire = 1'b1; target_row = 4'd3; target_col = 4'd3;
        @(negedge clk);
        new_game = 1'b0; fire = 1'b0;
        check("ng_over_fire_busy", 128'(busy), 128'(0));
        repeat (3) @(negedge clk);
        check("ng_over_fire_turns", 128'(turns_left), 128'(20));
        check("ng_over_fire_map", 128'(shot_map), 128'(0));

        // Twenty misses exhaust the turns
        pulse_new_game();
        for (int i = 0; i < 20; i++)
            shoot(2 + i / 10, i % 10, RES_MISS, 19 - i, 0, 1'b0, (i == 19));
        ignored_fire(4, 0);
        check("lose_hold_turns", 128'(turns_left), 128'(0));
        check("lose_hold_lose", 128'(lose), 128'(1));
        check("lose_hold_win", 128'(win), 128'(0));
        check("lose_hold_map", 128'(shot_map), 128'(exp_map));
        check("lose_hold_result", 128'(result), 128'(RES_MISS));

        // Three misses then seventeen hits: winning hit lands on the last turn
        pulse_new_game();
        for (int i = 0; i < 3; i++)
            shoot(2, i, RES_MISS, 19 - i, 0, 1'b0, 1'b0);
        for (int k = 1; k <= 17; k++)
            shoot(ship_idx[k-1] / 10, ship_idx[k-1] % 10, RES_HIT, 17 - k, k, (k == 17), 1'b0);
        ignored_fire(2, 5);
        check("win_hold_win", 128'(win), 128'(1));
        check("win_hold_lose", 128'(lose), 128'(0));
        check("win_hold_turns", 128'(turns_left), 128'(0));
        check("win_hold_hits", 128'(hits), 128'(17));
        check("win_hold_map", 128'(shot_map), 128'(exp_map));

        // new_game while in WIN
        pulse_new_game();
        check_reset_values("ng_win");

        // Asynchronous reset during CHECK aborts the shot
        shoot(2, 3, RES_MISS, 19, 0, 1'b0, 1'b0);
        exp_map = '0;
        begin
            exp_t e;
            e.res = RES_NONE; e.turns = 5'd20; e.hits = 5'd0; e.win = 1'b0; e.lose = 1'b0; e.smap = '0;
            sb_q.push_back(e);
        end
        @(negedge clk);
        target_row = 4'd0; target_col = 4'd0; fire = 1'b1;
        @(negedge clk);
        fire = 1'b0;
        #2 reset = 1'b1;
        #1 check_reset_values("async_rst");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        shoot(0, 0, RES_HIT, 19, 1, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("sb_drained", 128'(sb_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
